// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared fetch constants, FSM encodings and the queue entry type
package rv_fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h00000013;
    localparam logic [0:0] RUN = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// sync_fifo: synchronous FIFO with registered storage, clear input and occupancy count
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic [WIDTH-1:0]        rdata,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = pop && count != 0;
    assign do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
    assign rdata = mem[rd_ptr];
    // pointers wrap naturally at DEPTH; clear empties the FIFO like reset
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // storage needs no reset, only the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: credit-limited instruction fetch with redirect flush; FETCH_QUEUE_BYPASS_EN adds an empty-queue bypass
module fetch_queue
    import rv_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_i,
    output logic             pc_en_o,
    input  logic             redirect_i,
    output logic             imem_req_valid_o,
    input  logic             imem_req_ready_i,
    output logic [XLEN-1:0]  imem_req_addr_o,
    input  logic             imem_rsp_valid_i,
    input  logic [XLEN-1:0]  imem_rsp_data_i,
    output logic             id_valid_o,
    input  logic             id_ready_i,
    output logic [XLEN-1:0]  id_instr_o,
    output logic [XLEN-1:0]  id_pc_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [0:0] state;
    logic [CW-1:0] in_flight, drop_cnt, left, q_count, a_count;
    logic run, credit, req_fire, rsp_dec, rsp_keep, q_empty, q_push, q_pop, bypass;
    logic [XLEN-1:0] a_rdata;
    fetch_entry_t q_wdata, q_rdata;
    assign run = !rst && state == RUN;
    assign credit = {1'b0, in_flight} + {1'b0, q_count} < (CW+1)'(DEPTH);
    assign imem_req_valid_o = run && !redirect_i && credit;
    assign imem_req_addr_o = pc_i & ~32'h3;
    assign req_fire = imem_req_valid_o && imem_req_ready_i;
    assign pc_en_o = req_fire || (redirect_i && !rst);
    assign rsp_dec = imem_rsp_valid_i && in_flight != 0;
    assign rsp_keep = imem_rsp_valid_i && run && !redirect_i && a_count != 0;
    assign left = in_flight - CW'(rsp_dec);
    assign q_empty = q_count == 0;
    assign q_wdata = '{pc: a_rdata, instr: imem_rsp_data_i};
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = rsp_keep && q_empty;
    assign q_push = rsp_keep && !(bypass && id_ready_i);
`else
    assign bypass = 1'b0;
    assign q_push = rsp_keep;
`endif
    assign id_valid_o = !rst && (!q_empty || bypass);
    assign q_pop = id_valid_o && id_ready_i && !q_empty;
    assign id_instr_o = !id_valid_o ? INSTR_NOP : bypass ? imem_rsp_data_i : q_rdata.instr;
    assign id_pc_o = !id_valid_o ? '0 : bypass ? a_rdata : q_rdata.pc;

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_fifo (
        .clk(clk), .rst(rst), .clr(redirect_i), .push(req_fire), .pop(rsp_keep),
        .wdata(imem_req_addr_o), .rdata(a_rdata), .count(a_count)
    );

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk(clk), .rst(rst), .clr(redirect_i), .push(q_push), .pop(q_pop),
        .wdata(q_wdata), .rdata(q_rdata), .count(q_count)
    );

    // outstanding-fetch tracking and RUN/FLUSH control; in_flight counts every outstanding fetch, stale or not
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            in_flight <= '0;
            drop_cnt <= '0;
        end else begin
            in_flight <= left + CW'(req_fire);
            if (redirect_i) begin
                drop_cnt <= left;
                state <= left != 0 ? FLUSH : RUN;
            end else if (state == FLUSH && rsp_dec) begin
                drop_cnt <= drop_cnt - 1'b1;
                state <= drop_cnt == CW'(1) ? RUN : FLUSH;
            end
        end
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries and max in-flight fetches; power of two, >=2.
REQ-002 clk  in  1  single clock; all state updates on posedge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pc_i  in  32  current PC from the PC counter.
REQ-005 pc_en_o  out  1  enable to the PC counter (advance or redirect load).
REQ-006 redirect_i  in  1  branch/jump resolved taken in EX; PC counter loads its new target this cycle.
REQ-007 imem_req_valid_o / imem_req_ready_i  out/in  1/1  fetch request handshake.
REQ-008 imem_req_addr_o  out  32  fetch address, = {pc_i[31:2],2'b00}.
REQ-009 imem_rsp_valid_i / imem_rsp_data_i  in/in  1/32  in-order instruction responses, latency >=1 cycle, no backpressure.
REQ-010 id_valid_o / id_ready_i  out/in  1/1  decode-side handshake.
REQ-011 id_instr_o / id_pc_o  out/out  32/32  instruction and its fetch PC.

Function
REQ-012 Credit rule: imem_req_valid_o=1 only in RUN, redirect_i=0, and (in_flight + occupancy) < DEPTH.
REQ-013 pc_en_o = (imem_req_valid_o & imem_req_ready_i) | redirect_i; PC therefore steps +4 exactly once per accepted request.
REQ-014 Each accepted request pushes imem_req_addr_o into an internal address FIFO; each kept response pairs with the popped address into the queue.
REQ-015 Queue pop when id_valid_o & id_ready_i; push and pop in the same cycle are both honoured, occupancy unchanged.
REQ-016 id_valid_o=0 implies id_instr_o=32'h00000013 (NOP), id_pc_o=0.
REQ-017 Latency: request accepted at t, response at t+L, id_valid_o earliest at t+L+1 (without bypass).
REQ-018 FSM states RUN, FLUSH; reset enters RUN.
REQ-019 redirect_i in any state: queue and address FIFO cleared; drop_cnt <= in_flight minus any response arriving that cycle; next state FLUSH if drop_cnt>0, else RUN.
REQ-020 FLUSH: no requests; each response decrements drop_cnt and is discarded; drop_cnt reaching 0 -> RUN next cycle.
REQ-021 Response arriving in the redirect cycle is discarded; id_valid_o=0 in the cycle after redirect.
REQ-022 Pointers wrap modulo DEPTH; in_flight and drop_cnt are $clog2(DEPTH)+1 bits, never overflow under REQ-012.
REQ-023 Response with in_flight=0 in RUN is a protocol error: discarded, no state change.

Reset
REQ-024 On rst=1 at posedge: queue empty, in_flight=0, drop_cnt=0, state RUN.
REQ-025 While rst=1: imem_req_valid_o=0, pc_en_o=0, id_valid_o=0; reset mid-flight abandons outstanding fetches (imem shares rst).

Configuration
REQ-026 Macro FETCH_QUEUE_BYPASS_EN: when defined, a kept response with queue empty drives id_valid_o/id_instr_o/id_pc_o combinationally that cycle, and is enqueued only if id_ready_i=0.
REQ-027 Without FETCH_QUEUE_BYPASS_EN: every response is enqueued; id path fully registered, latency per REQ-017.

Structure
REQ-028 Shared package rv_fetch_pkg: XLEN=32, INSTR_NOP=32'h00000013, fetch-entry type {pc, instr}.
REQ-029 One sub-module sync_fifo (parameterised width/depth, registered storage) instantiated for queue and address FIFO; FSM and credit logic in fetch_queue.

Verification
REQ-030 Reset, pc_i=0, ready=1, rsp L=1 -> pc_en_o pulses each cycle; id sees PCs 0x0,0x4,0x8 with matching data, first at cycle 3.
REQ-031 id_ready_i=0, imem L=1, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid_o=0, pc_en_o=0 until a pop.
REQ-032 3 in flight, redirect_i=1 with no response that cycle -> next 3 responses dropped, FLUSH 3 cycles, first new request in RUN; no stale instr on id.
REQ-033 Redirect in same cycle as response with 2 in flight -> that response dropped, drop_cnt=1.
REQ-034 Full queue, pop and push same cycle -> occupancy stays 4, order preserved.
REQ-035 With FETCH_QUEUE_BYPASS_EN, empty queue, rsp data 0x00500093 at PC 0x10 -> id_valid_o=1 same cycle with that data/PC.
